// File: rtl/instruction_decode_pkg.sv
// Shared decode definitions: opcodes, operation classes, stage states and the
// opcode-to-class lookup used by the decode stage.
package instruction_decode_pkg;

    localparam logic [6:0] OPC_ALU_R  = 7'b0110011;
    localparam logic [6:0] OPC_ALU_I  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ALU_R   = 3'd0,
        ALU_I   = 3'd1,
        LOAD    = 3'd2,
        STORE   = 3'd3,
        BRANCH  = 3'd4,
        JUMP    = 3'd5,
        UPPER   = 3'd6,
        SYS_ILL = 3'd7
    } op_class_e;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    function automatic op_class_e opcode_class(input logic [6:0] opc);
        op_class_e cls;
        case (opc)
            OPC_ALU_R:           cls = ALU_R;
            OPC_ALU_I:           cls = ALU_I;
            OPC_LOAD:            cls = LOAD;
            OPC_STORE:           cls = STORE;
            OPC_BRANCH:          cls = BRANCH;
            OPC_JAL, OPC_JALR:   cls = JUMP;
            OPC_LUI, OPC_AUIPC:  cls = UPPER;
            default:             cls = SYS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/instruction_decode_imm_gen.sv
// Combinational immediate extraction; the format is chosen by the opcode.
module imm_gen
    import instruction_decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'd0;
        case (instr[6:0])
            OPC_ALU_I, OPC_LOAD, OPC_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'd0};
            OPC_JAL:
                imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: registers decoded fields on each accepted fetch transfer and
// stops accepting after an all-zero (halt) word until reset.
module instruction_decode
    import instruction_decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] imm,
    output logic [2:0]  op_class,
    output logic        illegal,
    output logic        halt,
    output logic [15:0] instr_count,
    output logic        state_dbg
);

    // Handshakes: a transfer happens on a cycle where valid && ready are both
    // high; the producer holds its payload until then, and in_ready depends
    // combinationally on out_ready so a draining bundle frees the slot at once.
    state_e    state;
    logic      accept;
    logic      is_halt;
    op_class_e class_next;
    logic [31:0] imm_next;

    assign in_ready   = !reset && (state == RUN) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign is_halt    = (in_instr == 32'd0);
    assign class_next = opcode_class(in_instr[6:0]);
    assign state_dbg  = state;

    imm_gen u_imm_gen (
        .instr (in_instr),
        .imm   (imm_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            out_valid   <= 1'b0;
            out_pc      <= 32'd0;
            rd          <= 5'd0;
            rs1         <= 5'd0;
            rs2         <= 5'd0;
            funct3      <= 3'd0;
            funct7      <= 7'd0;
            imm         <= 32'd0;
            op_class    <= 3'd0;
            illegal     <= 1'b0;
            halt        <= 1'b0;
            instr_count <= 16'd0;
        end else if (accept) begin
            // Fields load only here so idle cycles leave the outputs quiet.
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            rd          <= in_instr[11:7];
            rs1         <= in_instr[19:15];
            rs2         <= in_instr[24:20];
            funct3      <= in_instr[14:12];
            funct7      <= in_instr[31:25];
            imm         <= imm_next;
            op_class    <= class_next;
            illegal     <= (class_next == SYS_ILL) && !is_halt;
            halt        <= is_halt;
            if (instr_count != 16'hFFFF)
                instr_count <= instr_count + 16'd1;
            if (is_halt)
                state <= HALTED;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed plus randomized bench for instruction_decode with a queue-based
// reference model of the decode rules.
module tb_instruction_decode;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [2:0]  cls;
        logic        ill;
        logic        hlt;
    } bundle_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = 32'd0;
    logic [31:0] in_instr = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  op_class;
    logic        illegal;
    logic        halt;
    logic [15:0] instr_count;
    logic        state_dbg;

    bundle_t     exp_q[$];
    bundle_t     last_b;
    logic [15:0] exp_count;
    logic        halted;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_drained = 0;

    instruction_decode dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct3      (funct3),
        .funct7      (funct7),
        .imm         (imm),
        .op_class    (op_class),
        .illegal     (illegal),
        .halt        (halt),
        .instr_count (instr_count),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the instruction-set rules.
    function automatic bundle_t decode(input logic [31:0] pc, input logic [31:0] w);
        bundle_t b;
        b.pc  = pc;
        b.rd  = w[11:7];
        b.rs1 = w[19:15];
        b.rs2 = w[24:20];
        b.f3  = w[14:12];
        b.f7  = w[31:25];
        b.ill = 1'b0;
        b.hlt = 1'b0;
        case (w[6:0])
            7'h33: begin b.cls = 3'd0; b.imm = 32'd0; end
            7'h13: begin b.cls = 3'd1; b.imm = 32'($signed(w[31:20])); end
            7'h03: begin b.cls = 3'd2; b.imm = 32'($signed(w[31:20])); end
            7'h23: begin b.cls = 3'd3; b.imm = 32'($signed({w[31:25], w[11:7]})); end
            7'h63: begin b.cls = 3'd4; b.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); end
            7'h6F: begin b.cls = 3'd5; b.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
            7'h67: begin b.cls = 3'd5; b.imm = 32'($signed(w[31:20])); end
            7'h37, 7'h17: begin b.cls = 3'd6; b.imm = w & 32'hFFFF_F000; end
            default: begin
                b.cls = 3'd7;
                b.imm = 32'd0;
                b.hlt = (w == 32'd0);
                b.ill = (w != 32'd0);
            end
        endcase
        return b;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        last_b    = '0;
        exp_count = 16'd0;
        halted    = 1'b0;
    endtask

    task automatic check_outputs(input logic exp_ov);
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        chk("out_pc", out_pc, last_b.pc);
        chk("rd_rs1_rs2", {17'd0, rd, rs1, rs2}, {17'd0, last_b.rd, last_b.rs1, last_b.rs2});
        chk("funct3_funct7", {22'd0, funct3, funct7}, {22'd0, last_b.f3, last_b.f7});
        chk("imm", imm, last_b.imm);
        chk("class_ill_halt", {27'd0, op_class, illegal, halt},
            {27'd0, last_b.cls, last_b.ill, last_b.hlt});
        chk("instr_count", {16'd0, instr_count}, {16'd0, exp_count});
        chk("state", {31'd0, state_dbg}, {31'd0, halted});
    endtask

    // One cycle: drive at the falling edge, check, then predict the rising edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] w,
                        input logic ordy);
        logic exp_ov, exp_rdy;
        in_valid = v; in_pc = pc; in_instr = w; out_ready = ordy;
        #1;
        exp_ov  = (exp_q.size() != 0);
        exp_rdy = !halted && (!exp_ov || ordy);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        check_outputs(exp_ov);
        if (exp_ov && ordy) begin
            chk("drain_pc", out_pc, exp_q[0].pc);
            void'(exp_q.pop_front());
            n_drained++;
        end
        if (v && exp_rdy) begin
            last_b = decode(pc, w);
            exp_q.push_back(last_b);
            if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
            if (w == 32'd0) halted = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b1; in_instr = 32'h0050_0093; out_ready = 1'b0;
        #1;
        chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        model_reset();
    endtask

    function automatic logic [31:0] rand_word();
        logic [6:0]  opcs [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(0, 9) == 0) return (r == 32'd0) ? 32'h1 : r;
        return {r[31:7], opcs[$urandom_range(0, 8)]};
    endfunction

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        step(1'b0, 32'd0, 32'd0, 1'b1);

        // ADDI x1,x0,5
        step(1'b1, 32'h0, 32'h0050_0093, 1'b1);
        chk("addi_imm_direct", imm, 32'd5);
        chk("addi_class_direct", {29'd0, op_class}, 32'd1);
        // SW x2,8(x1) then stall three cycles with fetch pushing
        step(1'b1, 32'h4, 32'h0020_A423, 1'b1);
        chk("sw_imm_direct", imm, 32'd8);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h8, 32'hFE00_0EE3, 1'b0);
        // BEQ x0,x0,-4
        step(1'b1, 32'h8, 32'hFE00_0EE3, 1'b1);
        chk("beq_imm_direct", imm, 32'hFFFF_FFFC);
        // Illegal word, then the stream continues
        step(1'b1, 32'hC, 32'hFFFF_FFFF, 1'b1);
        chk("illegal_direct", {31'd0, illegal}, 32'd1);
        step(1'b1, 32'h10, 32'h0000_006F, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1);

        // Four back-to-back words with out_ready 1,0,1,1
        do_reset();
        n_drained = 0;
        step(1'b1, 32'h100, 32'h0020_81B3, 1'b1);
        step(1'b1, 32'h104, 32'h0040_A283, 1'b1);
        step(1'b1, 32'h108, 32'h1234_5037, 1'b0);
        step(1'b1, 32'h108, 32'h1234_5037, 1'b1);
        step(1'b1, 32'h10C, 32'h8000_0067, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("stream_count", {16'd0, instr_count}, 32'd4);
        chk("stream_drained", n_drained, 32'd4);

        // Halt while a previous bundle drains, then fetch keeps pushing
        step(1'b1, 32'h200, 32'h0010_0113, 1'b1);
        step(1'b1, 32'h204, 32'h0000_0000, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h208, 32'h0050_0093, i[0]);
        chk("halt_frozen_count", {16'd0, instr_count}, 32'd6);
        // Reset with a pending bundle, then acceptance resumes
        step(1'b1, 32'h208, 32'h0050_0093, 1'b0);
        do_reset();
        step(1'b1, 32'h300, 32'h0050_0093, 1'b1);
        step(1'b1, 32'h304, 32'h0000_0000, 1'b0);
        step(1'b1, 32'h308, 32'h0020_A423, 1'b0);
        do_reset();

        // Randomized traffic; reset whenever the stage halts
        for (int i = 0; i < 600; i++) begin
            logic [31:0] w;
            w = ($urandom_range(0, 49) == 0) ? 32'd0 : rand_word();
            step($urandom_range(0, 3) != 0, $urandom() & 32'hFFFF_FFFC, w,
                 $urandom_range(0, 2) != 0);
            if (halted && $urandom_range(0, 3) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
